// File: rtl/dmem_mmio_pkg.sv
// Shared constants and types for the data-memory / MMIO slave.
package dmem_mmio_pkg;

  // MMIO register byte offsets from the window base
  localparam int unsigned OFF_TXDATA = 0;
  localparam int unsigned OFF_STATUS = 4;
  localparam int unsigned OFF_CTRL   = 8;

  // STATUS register bit positions
  localparam int STAT_FULL   = 0;
  localparam int STAT_EMPTY  = 1;
  localparam int STAT_OVF    = 2;
  localparam int STAT_CNT_LO = 4;
  localparam int STAT_CNT_HI = 7;

  // CTRL register bit positions
  localparam int CTRL_CLR_OVF = 0;

  typedef enum logic [2:0] {
    RGN_RAM,
    RGN_TXDATA,
    RGN_STATUS,
    RGN_CTRL,
    RGN_UNMAPPED
  } region_e;

  // Pack FIFO state into the low byte of the STATUS register.
  function automatic logic [7:0] status_byte(input logic full, input logic empty,
                                             input logic ovf, input logic [3:0] cnt);
    logic [7:0] s;
    s = '0;
    s[STAT_FULL]                = full;
    s[STAT_EMPTY]               = empty;
    s[STAT_OVF]                 = ovf;
    s[STAT_CNT_HI:STAT_CNT_LO]  = cnt;
    return s;
  endfunction

endpackage

// File: rtl/dmem_mmio_tx_fifo.sv
// Show-ahead TX character FIFO with sticky overflow flag.
module tx_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;

  logic w_pop_acc;
  logic w_push_acc;
  logic w_drop;

  assign full     = (r_count == CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign overflow = r_ovf;

  // A pop on the same edge frees the slot, so a push into a full FIFO is still taken.
  assign w_pop_acc  = pop & ~empty;
  assign w_push_acc = push & (~full | w_pop_acc);
  assign w_drop     = push & full & ~w_pop_acc;

  // Head is shown directly; an empty FIFO presents zero rather than stale data.
  assign dout = empty ? '0 : r_mem[r_rd_ptr];

  // Pointer, count and overflow state; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A dropped byte outranks a simultaneous clear.
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push_acc) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data-memory slave: byte-strobed RAM, 1-cycle registered read, small MMIO window with TX FIFO.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int                  WORD_LEN    = 32,
  parameter int                  DEPTH_WORDS = 4096,
  parameter logic [WORD_LEN-1:0] MMIO_BASE   = 32'h0000_8000,
  parameter int                  FIFO_DEPTH  = 4,
  parameter                      INIT_FILE   = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD_LEN-1:0] addr_d,
  input  logic                wen,
  input  logic [WORD_LEN-1:0] wdata,
  input  logic [3:0]          wstrb,
  output logic [WORD_LEN-1:0] rdata,
  output logic                err,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready
);

  localparam int                  AW        = $clog2(DEPTH_WORDS);
  localparam int                  CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [WORD_LEN-1:0] RAM_BYTES = WORD_LEN'(DEPTH_WORDS * 4);
  localparam logic [WORD_LEN-1:0] A_TXDATA  = MMIO_BASE + WORD_LEN'(OFF_TXDATA);
  localparam logic [WORD_LEN-1:0] A_STATUS  = MMIO_BASE + WORD_LEN'(OFF_STATUS);
  localparam logic [WORD_LEN-1:0] A_CTRL    = MMIO_BASE + WORD_LEN'(OFF_CTRL);

  logic [WORD_LEN-1:0] r_mem [DEPTH_WORDS];
  logic [WORD_LEN-1:0] r_rdata;
  logic                r_err;

  region_e             w_region;
  logic [WORD_LEN-1:0] w_word_addr;
  logic [AW-1:0]       w_word_idx;
  logic                w_misaligned;
  logic                w_bad_wr;
  logic                w_wr_ok;
  logic                w_ram_we;
  logic                w_push;
  logic                w_pop;
  logic                w_clr_ovf;
  logic [WORD_LEN-1:0] w_rdata_nxt;
  logic [7:0]          w_fifo_dout;
  logic                w_full;
  logic                w_empty;
  logic [CW-1:0]       w_count;
  logic                w_ovf;

  assign w_word_addr  = {addr_d[WORD_LEN-1:2], 2'b00};
  assign w_word_idx   = addr_d[AW+1:2];
  assign w_misaligned = (addr_d[1:0] != 2'b00);

  // Address decode; MMIO registers match on the word address so misalignment is flagged separately.
  always_comb begin
    w_region = RGN_UNMAPPED;
    if (addr_d < RAM_BYTES)           w_region = RGN_RAM;
    else if (w_word_addr == A_TXDATA) w_region = RGN_TXDATA;
    else if (w_word_addr == A_STATUS) w_region = RGN_STATUS;
    else if (w_word_addr == A_CTRL)   w_region = RGN_CTRL;
  end

  // Bad writes are dropped entirely; only good writes reach RAM or the MMIO registers.
  assign w_bad_wr  = wen & ((w_region == RGN_UNMAPPED) | w_misaligned | (wstrb == 4'b0000));
  assign w_wr_ok   = wen & ~w_bad_wr;
  assign w_ram_we  = w_wr_ok & (w_region == RGN_RAM);
  assign w_push    = w_wr_ok & (w_region == RGN_TXDATA) & wstrb[0];
  assign w_clr_ovf = w_wr_ok & (w_region == RGN_CTRL) & wstrb[0] & wdata[CTRL_CLR_OVF];
  assign w_pop     = tx_valid & tx_ready;

  // Read mux; STATUS reflects pre-edge FIFO state.
  always_comb begin
    w_rdata_nxt = '0;
    case (w_region)
      RGN_RAM:    w_rdata_nxt = r_mem[w_word_idx];
      RGN_STATUS: w_rdata_nxt = WORD_LEN'(status_byte(w_full, w_empty, w_ovf, 4'(w_count)));
      default:    w_rdata_nxt = '0;
    endcase
  end

  // Registered read data and error pulse; read happens regardless of wen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_rdata <= w_rdata_nxt;
      r_err   <= w_bad_wr;
    end
  end

  // Byte-lane RAM write; non-blocking update gives read-first behaviour on a same-word access.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) r_mem[w_word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (w_push),
    .din      (wdata[7:0]),
    .pop      (w_pop),
    .clr_ovf  (w_clr_ovf),
    .dout     (w_fifo_dout),
    .full     (w_full),
    .empty    (w_empty),
    .count    (w_count),
    .overflow (w_ovf)
  );

  assign rdata    = r_rdata;
  assign err      = r_err;
  assign tx_data  = w_fifo_dout;
  assign tx_valid = ~w_empty;

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: directed scenarios plus randomized traffic against a queue/array model.
module tb_dmem_mmio;

  localparam logic [31:0] BASE = 32'h0000_8000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_d;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        err;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int nvec  = 0;
  int nfail = 0;

  dmem_mmio dut (
    .clk      (clk),
    .rst      (rst),
    .addr_d   (addr_d),
    .wen      (wen),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .rdata    (rdata),
    .err      (err),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_ram [4096];
  bit          m_known [4096];
  logic [7:0]  m_q [$];
  bit          m_ovf;
  logic [31:0] e_rdata;
  bit          e_rd_known;
  bit          e_err;

  function automatic void chk(input string n, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", n, got, want, $time);
    end
  endfunction

  // Model: advance one clock edge from the specification's rules
  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_ovf      = 0;
      e_rdata    = 0;
      e_rd_known = 1;
      e_err      = 0;
    end else begin
      logic [31:0] ab;
      bit is_ram, is_tx, is_st, is_ctl, mapped, mis, bad, ok, pop, push, clr, drop;
      int n, w;
      ab     = {addr_d[31:2], 2'b00};
      is_ram = addr_d < 32'h4000;
      is_tx  = !is_ram && ab == BASE;
      is_st  = ab == BASE + 32'd4;
      is_ctl = ab == BASE + 32'd8;
      mapped = is_ram || is_tx || is_st || is_ctl;
      mis    = addr_d[1:0] != 2'b00;
      n      = m_q.size();
      w      = int'(addr_d[13:2]);
      e_rd_known = 1;
      e_rdata    = 0;
      if (is_ram) begin
        e_rd_known = m_known[w];
        e_rdata    = m_ram[w];
      end else if (mapped && mis) begin
        e_rd_known = 0;
      end else if (is_st) begin
        e_rdata = 32'(n) * 16 + (m_ovf ? 32'd4 : 32'd0) + (n == 0 ? 32'd2 : 32'd0) + (n == 4 ? 32'd1 : 32'd0);
      end
      bad   = wen && (!mapped || mis || wstrb == 4'b0000);
      e_err = bad;
      ok    = wen && !bad;
      if (ok && is_ram) begin
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) m_ram[w][8*b +: 8] = wdata[8*b +: 8];
        if (wstrb == 4'hF) m_known[w] = 1;
      end
      pop  = tx_ready && n > 0;
      push = ok && is_tx && wstrb[0];
      clr  = ok && is_ctl && wstrb[0] && wdata[0];
      drop = push && n == 4 && !pop;
      if (pop) void'(m_q.pop_front());
      if (push && !drop) m_q.push_back(wdata[7:0]);
      if (drop)     m_ovf = 1;
      else if (clr) m_ovf = 0;
    end
  end

  // Compare every cycle, just after the edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (e_rd_known) chk("rdata", rdata, e_rdata);
        chk("err", 32'(err), 32'(e_err));
        chk("tx_valid", 32'(tx_valid), (m_q.size() != 0) ? 32'd1 : 32'd0);
        chk("tx_data", 32'(tx_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
      end
    end
  end

  task automatic step(input logic [31:0] a, input logic we, input logic [31:0] d,
                      input logic [3:0] s, input logic rdy);
    @(negedge clk);
    addr_d = a; wen = we; wdata = d; wstrb = s; tx_ready = rdy;
    @(posedge clk);
    #2;
  endtask

  task automatic lit_rd(input string n, input logic [31:0] want);
    chk({n, " dut"}, rdata, want);
    chk({n, " model"}, e_rdata, want);
  endtask

  task automatic idle_inputs();
    addr_d = 32'h10; wen = 0; wdata = 0; wstrb = 0; tx_ready = 0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] unm [4];
    unm[0] = 32'h4000_0000; unm[1] = BASE + 32'd12; unm[2] = 32'hFFFF_FFFC; unm[3] = 32'h0000_4000;

    rst = 1;
    idle_inputs();
    #1;
    chk("reset rdata", rdata, 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset tx_valid", 32'(tx_valid), 32'd0);
    chk("reset tx_data", 32'(tx_data), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;

    // Byte-strobe merge
    step(32'h10, 1, 32'hDEADBEEF, 4'b1111, 0);
    step(32'h10, 1, 32'h0000_5500, 4'b0010, 0);
    step(32'h10, 0, 32'h0, 4'b0000, 0);
    lit_rd("strobe merge", 32'hDEAD55EF);

    // Read-during-write returns the old word
    step(32'h20, 1, 32'h7, 4'hF, 0);
    step(32'h20, 1, 32'h1, 4'hF, 0);
    lit_rd("read-first old", 32'h7);
    step(32'h20, 0, 32'h0, 4'h0, 0);
    lit_rd("read-first new", 32'h1);

    // Fill, overflow, drain
    for (int i = 0; i < 4; i++) step(BASE, 1, 32'h41 + 32'(i), 4'hF, 0);
    step(BASE + 4, 0, 0, 0, 0);
    lit_rd("status full", 32'h41);
    step(BASE, 1, 32'h45, 4'hF, 0);
    chk("overflow push err", 32'(err), 32'd0);
    step(BASE + 4, 0, 0, 0, 0);
    lit_rd("status ovf", 32'h45);
    chk("head A", 32'(tx_data), 32'h41);
    for (int i = 0; i < 3; i++) begin
      step(32'h10, 0, 0, 0, 1);
      chk("drain", 32'(tx_data), 32'h42 + 32'(i));
    end
    step(32'h10, 0, 0, 0, 1);
    chk("drained valid", 32'(tx_valid), 32'd0);
    step(BASE + 8, 1, 32'h1, 4'hF, 0);
    step(BASE + 4, 0, 0, 0, 0);
    lit_rd("status cleared", 32'h02);

    // Push into a full FIFO while popping
    for (int i = 0; i < 4; i++) step(BASE, 1, 32'h31 + 32'(i), 4'hF, 0);
    step(BASE, 1, 32'h5A, 4'hF, 1);
    step(BASE + 4, 0, 0, 0, 0);
    lit_rd("status full+pop push", 32'h41);
    chk("head after pop", 32'(tx_data), 32'h32);
    step(32'h10, 0, 0, 0, 1);
    step(32'h10, 0, 0, 0, 1);
    step(32'h10, 0, 0, 0, 1);
    chk("Z after 4 pops", 32'(tx_data), 32'h5A);
    step(32'h10, 0, 0, 0, 1);
    chk("empty after Z", 32'(tx_valid), 32'd0);

    // Bad writes
    step(32'h4000_0000, 1, 32'h1234, 4'hF, 0);
    chk("unmapped err", 32'(err), 32'd1);
    step(32'h10, 0, 0, 0, 0);
    chk("err one cycle", 32'(err), 32'd0);
    step(32'h13, 1, 32'hFFFF_FFFF, 4'hF, 0);
    chk("misaligned err", 32'(err), 32'd1);
    step(32'h10, 0, 0, 0, 0);
    lit_rd("misaligned dropped", 32'hDEAD55EF);
    step(32'h10, 1, 32'hFFFF_FFFF, 4'h0, 0);
    chk("zero strobe err", 32'(err), 32'd1);

    // Asynchronous reset with bytes queued
    for (int i = 0; i < 3; i++) step(BASE, 1, 32'h61 + 32'(i), 4'hF, 0);
    @(negedge clk);
    idle_inputs();
    #3;
    rst = 1;
    #1;
    chk("async tx_valid", 32'(tx_valid), 32'd0);
    chk("async tx_data", 32'(tx_data), 32'd0);
    @(posedge clk);
    @(negedge clk); rst = 0;
    step(BASE + 4, 0, 0, 0, 0);
    lit_rd("status after reset", 32'h02);
    for (int i = 0; i < 5; i++) step(BASE, 1, 32'h70 + 32'(i), 4'hF, 0);
    step(BASE + 8, 1, 32'h1, 4'hF, 0);
    step(BASE + 4, 0, 0, 0, 0);
    lit_rd("ctrl clear", 32'h41);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] s;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: a = 32'($urandom_range(0, 15)) * 4;
        5:       a = BASE;
        6:       a = BASE + 32'd4;
        7:       a = BASE + 32'd8;
        8:       a = unm[$urandom_range(0, 3)];
        default: a = ($urandom_range(0, 1) == 0 ? 32'($urandom_range(0, 15)) * 4 : BASE + 32'($urandom_range(0, 2)) * 4)
                     + 32'($urandom_range(1, 3));
      endcase
      s = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      step(a, 1'($urandom_range(0, 1)), $urandom, s, ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
